// File: rtl/rle_pkg.sv
// Shared constants, token layout and FSM state encoding for the run-length encoder
// and its companion token decoder.
package rle_pkg;

  localparam int DATA_W  = 32'd8;
  localparam int LEN_W   = 32'd2;
  localparam int IDX_W   = 32'd32;
  localparam int TOK_W   = LEN_W + 32'd1;
  localparam int MAX_RUN = (32'd1 << LEN_W) - 32'd1;
  localparam int VAL_BIT = LEN_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    EMIT  = 3'd3,
    FLUSH = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Token word: bit value in the top bit, run length below it.
  function automatic logic [TOK_W-1:0] make_tok(input logic val, input logic [LEN_W-1:0] len);
    logic [TOK_W-1:0] t;
    t                = {TOK_W{1'b0}};
    t[VAL_BIT]       = val;
    t[LEN_W-1:0]     = len;
    return t;
  endfunction

endpackage

// File: rtl/rle_compress_if.sv
// Byte-in / token-out handshake bundle of the run-length encoder.
interface rle_compress_if;
  import rle_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [TOK_W-1:0]  tok_out;
  logic              tok_valid;
  logic              tok_last;
  logic              tok_ready;

  modport master (
    output in_data, in_valid, in_last, tok_ready,
    input  in_ready, tok_out, tok_valid, tok_last
  );

  modport slave (
    input  in_data, in_valid, in_last, tok_ready,
    output in_ready, tok_out, tok_valid, tok_last
  );

endinterface

// File: rtl/rle_bit_shifter.sv
// Holds the current byte, presents its next bit MSB-first and tracks the bit and
// byte position within the stream.
module rle_bit_shifter
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              consume_i,
  input  logic              byte_inc_i,
  input  logic              clear_i,
  output logic              bit_o,
  output logic              eob_o,
  output logic [3:0]        bit_indx_o,
  output logic [IDX_W-1:0]  byte_indx_o
);

  localparam logic [3:0]       BIT_LAST = 4'(DATA_W - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [3:0]        bit_indx_q, bit_indx_d;
  logic [IDX_W-1:0]  byte_indx_q, byte_indx_d;

  assign bit_o       = sh_q[DATA_W-1];
  assign eob_o       = (bit_indx_q == BIT_LAST);
  assign bit_indx_o  = bit_indx_q;
  assign byte_indx_o = byte_indx_q;

  // Next-state for shift register and position counters.
  always_comb begin
    sh_d        = sh_q;
    bit_indx_d  = bit_indx_q;
    byte_indx_d = byte_indx_q;
    if (clear_i) begin
      sh_d        = {DATA_W{1'b0}};
      bit_indx_d  = 4'd0;
      byte_indx_d = {IDX_W{1'b0}};
    end else begin
      if (load_i) begin
        sh_d       = data_i;
        bit_indx_d = 4'd0;
      end else if (consume_i) begin
        sh_d       = {sh_q[DATA_W-2:0], 1'b0};
        bit_indx_d = eob_o ? 4'd0 : (bit_indx_q + 4'd1);
      end else begin
        sh_d       = sh_q;
        bit_indx_d = bit_indx_q;
      end
      if (byte_inc_i) begin
        byte_indx_d = byte_indx_q + IDX_ONE;
      end else begin
        byte_indx_d = byte_indx_q;
      end
    end
  end

  // Position and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= {DATA_W{1'b0}};
      bit_indx_q  <= 4'd0;
      byte_indx_q <= {IDX_W{1'b0}};
    end else begin
      sh_q        <= sh_d;
      bit_indx_q  <= bit_indx_d;
      byte_indx_q <= byte_indx_d;
    end
  end

endmodule

// File: rtl/rle_compress.sv
// Run-length encoder: serializes bytes MSB-first into {value, run_len} tokens.
// Optional macro RLE_STATS_EN adds a saturating per-stream token counter output.
module rle_compress
  import rle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  rle_compress_if.slave    s,
  output logic [IDX_W-1:0] byte_indx,
  output logic [3:0]       bit_indx,
`ifdef RLE_STATS_EN
  output logic [15:0]      tok_count,
`endif
  output logic             done
);

  localparam logic [LEN_W-1:0] RUN_FULL = LEN_W'(MAX_RUN);
  localparam logic [LEN_W-1:0] RUN_ONE  = LEN_W'(1'b1);

  state_t            state_q;
  logic              run_val_q;
  logic [LEN_W-1:0]  run_len_q;
  logic              last_q;
  logic              in_ready_q;
  logic [TOK_W-1:0]  tok_out_q;
  logic              tok_valid_q;
  logic              tok_last_q;
  logic              done_q;

  logic              in_xfer_s;
  logic              tok_xfer_s;
  logic              cur_bit_s;
  logic              eob_s;
  logic              consume_s;
  logic              byte_inc_s;
  logic              clear_s;
  logic              new_val_s;
  logic [LEN_W-1:0]  new_len_s;

  assign in_xfer_s   = s.in_valid & in_ready_q;
  assign tok_xfer_s  = tok_valid_q & s.tok_ready;
  assign clear_s     = (state_q == DONE);
  assign byte_inc_s  = (consume_s & eob_s & ~last_q) | ((state_q == FLUSH) & tok_xfer_s);

  assign s.in_ready  = in_ready_q;
  assign s.tok_out   = tok_out_q;
  assign s.tok_valid = tok_valid_q;
  assign s.tok_last  = tok_last_q;
  assign done        = done_q;

  rle_bit_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (in_xfer_s),
    .data_i      (s.in_data),
    .consume_i   (consume_s),
    .byte_inc_i  (byte_inc_s),
    .clear_i     (clear_s),
    .bit_o       (cur_bit_s),
    .eob_o       (eob_s),
    .bit_indx_o  (bit_indx),
    .byte_indx_o (byte_indx)
  );

  // Decide whether the current bit extends the run; a full run always forces a token.
  always_comb begin
    consume_s = 1'b0;
    new_val_s = run_val_q;
    new_len_s = run_len_q;
    if (state_q == SCAN) begin
      if (run_len_q == {LEN_W{1'b0}}) begin
        consume_s = 1'b1;
        new_val_s = cur_bit_s;
        new_len_s = RUN_ONE;
      end else if ((cur_bit_s == run_val_q) && (run_len_q != RUN_FULL)) begin
        consume_s = 1'b1;
        new_len_s = run_len_q + RUN_ONE;
      end else begin
        consume_s = 1'b0;
      end
    end else begin
      consume_s = 1'b0;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_val_q   <= 1'b0;
      run_len_q   <= {LEN_W{1'b0}};
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      tok_out_q   <= {TOK_W{1'b0}};
      tok_valid_q <= 1'b0;
      tok_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (in_xfer_s) begin
            last_q     <= s.in_last;
            in_ready_q <= 1'b0;
            state_q    <= SCAN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (consume_s) begin
            run_val_q <= new_val_s;
            run_len_q <= new_len_s;
            if (eob_s) begin
              if (last_q) begin
                tok_out_q   <= make_tok(new_val_s, new_len_s);
                tok_valid_q <= 1'b1;
                tok_last_q  <= 1'b1;
                state_q     <= FLUSH;
              end else begin
                in_ready_q  <= 1'b1;
                state_q     <= LOAD;
              end
            end
          end else begin
            // The mismatching bit stays put and seeds the next run after the token.
            tok_out_q   <= make_tok(run_val_q, run_len_q);
            tok_valid_q <= 1'b1;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (tok_xfer_s) begin
            tok_valid_q <= 1'b0;
            run_len_q   <= {LEN_W{1'b0}};
            state_q     <= SCAN;
          end
        end
        FLUSH: begin
          if (tok_xfer_s) begin
            tok_valid_q <= 1'b0;
            tok_last_q  <= 1'b0;
            run_len_q   <= {LEN_W{1'b0}};
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          last_q     <= 1'b0;
          run_val_q  <= 1'b0;
          run_len_q  <= {LEN_W{1'b0}};
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          run_len_q   <= {LEN_W{1'b0}};
          in_ready_q  <= 1'b0;
          tok_valid_q <= 1'b0;
          tok_last_q  <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RLE_STATS_EN
  logic [15:0] tok_count_q;

  assign tok_count = tok_count_q;

  // Saturating token counter, held through DONE and cleared on leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_count_q <= 16'd0;
    end else if (state_q == DONE) begin
      tok_count_q <= 16'd0;
    end else if (tok_xfer_s && (tok_count_q != 16'hFFFF)) begin
      tok_count_q <= tok_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_compress.sv
// Directed bench for rle_compress: hand-computed token sequences, backpressure and reset.
module tb_rle_compress;
  import rle_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [IDX_W-1:0] byte_indx;
  logic [3:0]       bit_indx;
  logic             done;
`ifdef RLE_STATS_EN
  logic [15:0]      tok_count;
  logic [15:0]      cnt_at_done;
`endif

  rle_compress_if bus ();

  rle_compress dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus.slave),
    .byte_indx (byte_indx),
    .bit_indx  (bit_indx),
`ifdef RLE_STATS_EN
    .tok_count (tok_count),
`endif
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [TOK_W-1:0] got_tok[$];
  logic             got_last[$];
  int               cyc = 0;
  int               done_cnt = 0;
  int               last_cyc = 0;
  int               done_cyc = 0;
  logic [IDX_W-1:0] done_bidx;
  logic [TOK_W-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token / done monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (bus.tok_valid && bus.tok_ready) begin
        got_tok.push_back(bus.tok_out);
        got_last.push_back(bus.tok_last);
        if (bus.tok_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt  = done_cnt + 1;
        done_cyc  = cyc;
        done_bidx = byte_indx;
`ifdef RLE_STATS_EN
        cnt_at_done = tok_count;
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input string tag, input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_data  = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) chk({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - start), 32'd1);
    chk({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 32'd1);
    chk({tag, "_idx_cleared"}, byte_indx, 32'd0);
  endtask

  task automatic check_tokens(input string tag);
    chk({tag, "_ntok"}, 32'(got_tok.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_tok.size()) begin
        chk($sformatf("%s_tok%0d", tag, i), 32'(got_tok[i]), 32'(exp_q[i]));
        chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == exp_q.size() - 1));
      end
    end
`ifdef RLE_STATS_EN
    chk({tag, "_tok_count"}, 32'(cnt_at_done), 32'(exp_q.size()));
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.tok_ready = 1'b1;

    // Reset state.
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_tok_valid", 32'(bus.tok_valid), 32'd0);
    chk("rst_tok_out", 32'(bus.tok_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_byte_indx", byte_indx, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_0", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_1", 32'(bus.in_ready), 32'd1);

    // 0x7F single byte.
    got_tok.delete(); got_last.delete();
    feed("b7f", 8'h7F, 1'b1);
    wait_done("b7f");
    exp_q = '{3'b001, 3'b111, 3'b111, 3'b101};
    check_tokens("b7f");
    chk("b7f_bidx", done_bidx, 32'd1);

    // 0x00 single byte.
    got_tok.delete(); got_last.delete();
    feed("b00", 8'h00, 1'b1);
    wait_done("b00");
    exp_q = '{3'b011, 3'b011, 3'b010};
    check_tokens("b00");

    // Alternating bits: every run has length 1.
    got_tok.delete(); got_last.delete();
    feed("baa", 8'hAA, 1'b1);
    wait_done("baa");
    exp_q = '{3'b101, 3'b001, 3'b101, 3'b001, 3'b101, 3'b001, 3'b101, 3'b001};
    check_tokens("baa");

    // Runs spanning a byte boundary.
    got_tok.delete(); got_last.delete();
    feed("xb0", 8'hF0, 1'b0);
    feed("xb1", 8'h0F, 1'b1);
    wait_done("xb");
    exp_q = '{3'b111, 3'b101, 3'b011, 3'b011, 3'b010, 3'b111, 3'b101};
    check_tokens("xb");
    chk("xb_bidx", done_bidx, 32'd2);

    // Backpressure on the first token of 0x7F.
    got_tok.delete(); got_last.delete();
    bus.tok_ready = 1'b0;
    feed("bp", 8'h7F, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tok_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_tok_valid", 32'(bus.tok_valid), 32'd1);
      chk("bp_tok_out", 32'(bus.tok_out), 32'b001);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_bit_indx", 32'(bit_indx), 32'd1);
    @(posedge clk);
    #1;
    bus.tok_ready = 1'b1;
    wait_done("bp");
    exp_q = '{3'b001, 3'b111, 3'b111, 3'b101};
    check_tokens("bp");

    // Reset mid-stream, then a fresh stream.
    got_tok.delete(); got_last.delete();
    begin
      int dc;
      feed("mr", 8'hAA, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      dc    = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mr_tok_valid", 32'(bus.tok_valid), 32'd0);
      chk("mr_tok_last", 32'(bus.tok_last), 32'd0);
      chk("mr_tok_out", 32'(bus.tok_out), 32'd0);
      chk("mr_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mr_bit_indx", 32'(bit_indx), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("mr_no_done", 32'(done_cnt - dc), 32'd0);
      begin
        int nl;
        nl = 0;
        foreach (got_last[i]) if (got_last[i]) nl++;
        chk("mr_no_last", 32'(nl), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    got_tok.delete(); got_last.delete();
    feed("ff", 8'hFF, 1'b1);
    wait_done("ff");
    exp_q = '{3'b111, 3'b111, 3'b110};
    check_tokens("ff");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
